// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types: serial subtractor state encoding and default operand width
package alu_pkg;

    localparam int ALU_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        SS_IDLE = 2'd0,
        SS_RUN  = 2'd1,
        SS_DONE = 2'd2
    } ss_state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done handshake bundle for serial_subtractor
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, d, ovf);
    modport slave  (input start, a, b, output busy, done, d, ovf);
`else
    modport master (output start, a, b, input busy, done, d);
    modport slave  (input start, a, b, output busy, done, d);
`endif

endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - 1-bit full adder cell, shared with the ripple-carry adder
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor d = a - b, one bit per clock
// SERIAL_SUB_OVF_EN adds a registered signed-overflow flag alongside d.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    ss_state_e        state;
    ss_state_e        state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] nb_sh;
    logic [WIDTH-2:0] r_sh;
    logic [WIDTH-1:0] r_full;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   d_q;
    logic             sum;
    logic             cout;
    logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
    logic             ovf_q;
`endif

    // a - b is formed as a + ~b + 1: b is inverted on capture, carry seeded with 1
    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (nb_sh[0]),
        .cin  (carry),
        .s    (sum),
        .cout (cout)
    );

    assign r_full   = {sum, r_sh};
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SS_IDLE: if (bus.start) state_nxt = SS_RUN;
            SS_RUN:  if (last_bit)  state_nxt = SS_DONE;
            SS_DONE: state_nxt = SS_IDLE;
            default: state_nxt = SS_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == SS_RUN);
        bus.done = (state == SS_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            nb_sh <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            d_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
`endif
        end else begin
            case (state)
                SS_IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        nb_sh <= ~bus.b;
                        carry <= 1'b1;
                        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= bus.b[WIDTH-1];
`endif
                    end
                end
                SS_RUN: begin
                    a_sh  <= a_sh >> 1;
                    nb_sh <= nb_sh >> 1;
                    r_sh  <= r_full[WIDTH-1:1];
                    carry <= cout;
                    cnt   <= cnt + 1'b1;
                    // The final sum bit is still in flight, so d is taken from r_full, not r_sh
                    if (last_bit) begin
                        d_q   <= {~cout, r_full};
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q <= (a_msb ^ b_msb) & (a_msb ^ sum);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.d = d_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (optionally with SERIAL_SUB_OVF_EN)
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [W:0] ref_d(input logic [W-1:0] av, input logic [W-1:0] bv);
        int diff;
        diff = int'(av) - int'(bv);
        return (W+1)'(diff);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv);
        int sd;
        sd = int'($signed(av)) - int'($signed(bv));
        return (sd > (2**(W-1) - 1)) || (sd < -(2**(W-1)));
    endfunction

    // Issues one start pulse and observes W+4 cycles after the accepting edge.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int busy_cnt, output int done_cnt, output int done_at,
                          output int overlap, output logic [W:0] dv, output logic ov);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        busy_cnt  = 0;
        done_cnt  = 0;
        done_at   = -1;
        overlap   = 0;
        dv        = '0;
        ov        = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
                dv = bus.d;
`ifdef SERIAL_SUB_OVF_EN
                ov = bus.ovf;
`endif
            end
            if (bus.busy && bus.done) overlap++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.d !== '0) begin errors++; $display("FAIL reset_d: got %h want 0", bus.d); end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [W-1:0] ta [6] = '{8'd23, 8'd3, 8'd8, 8'd0, 8'd255, 8'd0};
        logic [W-1:0] tb [6] = '{8'd12, 8'd8, 8'd8, 8'd0, 8'd0,   8'd255};
        int bc, dc, da, ovl;
        logic [W:0] dv;
        logic ov;
        for (int k = 0; k < 6; k++) begin
            run_op(ta[k], tb[k], bc, dc, da, ovl, dv, ov);
            checks++; if (bc !== W) begin errors++; $display("FAIL vec%0d_busy_cycles: got %0d want %0d", k, bc, W); end
            checks++; if (dc !== 1) begin errors++; $display("FAIL vec%0d_done_count: got %0d want 1", k, dc); end
            checks++; if (da !== W) begin errors++; $display("FAIL vec%0d_done_latency: got %0d want %0d", k, da, W); end
            checks++; if (ovl !== 0) begin errors++; $display("FAIL vec%0d_busy_done_overlap: got %0d want 0", k, ovl); end
            checks++; if (dv !== ref_d(ta[k], tb[k])) begin errors++; $display("FAIL vec%0d_d: got %h want %h", k, dv, ref_d(ta[k], tb[k])); end
            checks++; if (bus.d !== ref_d(ta[k], tb[k])) begin errors++; $display("FAIL vec%0d_d_hold: got %h want %h", k, bus.d, ref_d(ta[k], tb[k])); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] av, bv;
        int bc, dc, da, ovl;
        logic [W:0] dv;
        logic ov;
        for (int k = 0; k < 25; k++) begin
            av = W'($urandom);
            bv = W'($urandom);
            run_op(av, bv, bc, dc, da, ovl, dv, ov);
            checks++; if (dv !== ref_d(av, bv) || dc !== 1 || da !== W || bc !== W || ovl !== 0) begin
                errors++;
                $display("FAIL rand%0d a=%0d b=%0d: got d=%h done=%0d at=%0d busy=%0d ovl=%0d want d=%h done=1 at=%0d busy=%0d ovl=0",
                         k, av, bv, dv, dc, da, bc, ovl, ref_d(av, bv), W, W);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++; if (ov !== ref_ovf(av, bv)) begin errors++; $display("FAIL rand%0d_ovf a=%h b=%h: got %b want %b", k, av, bv, ov, ref_ovf(av, bv)); end
`endif
        end
    endtask

    task automatic test_ignore_start();
        int dc = 0;
        logic [W:0] dv = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd71;
        bus.b     = 8'd35;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            if (i == 2) begin bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd1; end
            if (i == 3) bus.start = 1'b0;
            if (bus.done) begin dc++; dv = bus.d; end
            @(posedge clk);
            #1;
        end
        checks++; if (dc !== 1) begin errors++; $display("FAIL ignore_start_done_count: got %0d want 1", dc); end
        checks++; if (dv !== 9'h024) begin errors++; $display("FAIL ignore_start_d: got %h want 024", dv); end
        checks++; if (bus.d !== 9'h024) begin errors++; $display("FAIL ignore_start_d_hold: got %h want 024", bus.d); end
    endtask

    task automatic test_mid_reset();
        int bc, dc, da, ovl, late_done = 0;
        logic [W:0] dv;
        logic ov;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd200;
        bus.b     = 8'd100;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", bus.done); end
        checks++; if (bus.d !== '0) begin errors++; $display("FAIL midreset_d: got %h want 0", bus.d); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) late_done++;
        end
        checks++; if (late_done !== 0) begin errors++; $display("FAIL midreset_aborted_done: got %0d want 0", late_done); end
        run_op(8'd200, 8'd100, bc, dc, da, ovl, dv, ov);
        checks++; if (dv !== 9'd100 || dc !== 1) begin errors++; $display("FAIL midreset_rerun: got d=%h done=%0d want d=064 done=1", dv, dc); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pa [4];
        logic [W-1:0] pb [4];
        int idx = 0;
        int last = -1;
        for (int k = 0; k < 4; k++) begin
            pa[k] = W'($urandom);
            pb[k] = W'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = pa[0];
        bus.b     = pb[0];
        for (int cyc = 0; cyc < 5 * (W + 2) && idx < 4; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                checks++; if (bus.d !== ref_d(pa[idx], pb[idx])) begin errors++; $display("FAIL b2b%0d_d: got %h want %h", idx, bus.d, ref_d(pa[idx], pb[idx])); end
                if (last >= 0) begin
                    checks++; if (cyc - last !== W + 2) begin errors++; $display("FAIL b2b%0d_period: got %0d want %0d", idx, cyc - last, W + 2); end
                end
                last = cyc;
                idx++;
                if (idx < 4) begin
                    bus.a = pa[idx];
                    bus.b = pb[idx];
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        checks++; if (idx !== 4) begin errors++; $display("FAIL b2b_timeout: got %0d ops want 4", idx); end
        repeat (W + 4) @(posedge clk);
        #1;
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        int bc, dc, da, ovl;
        logic [W:0] dv;
        logic ov;
        run_op(8'h80, 8'h01, bc, dc, da, ovl, dv, ov);
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ovf_80m01: got %b want 1", ov); end
        checks++; if (dv[W-1:0] !== 8'h7F) begin errors++; $display("FAIL ovf_80m01_d: got %h want 7f", dv[W-1:0]); end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b want 1", bus.ovf); end
        run_op(8'd5, 8'd3, bc, dc, da, ovl, dv, ov);
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL ovf_5m3: got %b want 0", ov); end
        run_op(8'h7F, 8'hFF, bc, dc, da, ovl, dv, ov);
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ovf_7fmff: got %b want 1", ov); end
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing `d = a - b` one bit per clock over WIDTH cycles, with a start/done handshake. It is the inverse-operation companion to the combinational ripple-carry adder, used where area matters more than latency (e.g. multi-cycle ALU paths in the MIPS datapath). It uses a single shared 1-bit full-adder slice, computing `a + ~b + 1`. The result is WIDTH+1 bits wide to mirror the adder's sum width.

## Interface
- `WIDTH`, default 8: operand width in bits; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend, unsigned; captured when `start` is accepted.
- `b`  in  WIDTH  subtrahend, unsigned; captured when `start` is accepted.
- `busy`  out  1  high while bits are being processed (RUN).
- `done`  out  1  one-cycle pulse when `d` is valid.
- `d`  out  WIDTH+1  `{1'b0,a} - {1'b0,b}` in two's complement; `d[WIDTH]` = borrow (a < b).
- `ovf`  out  1  present only with SERIAL_SUB_OVF_EN; signed overflow of WIDTH-bit `a - b`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start=1` at a clock edge captures `a` and `~b` into shift registers, sets carry to 1, clears the bit counter, and moves to RUN.
  - `start=0` keeps the FSM in IDLE.
- RUN, each edge:
  - `s = a_sh[0] ^ nb_sh[0] ^ c`; next carry is `maj(a_sh[0], nb_sh[0], c)`.
  - `s` shifts into the result register from the MSB side; operand registers shift right; the counter increments.
- On the edge processing bit WIDTH-1:
  - `d[WIDTH-1:0]` is taken from the completed shift register.
  - `d[WIDTH] = ~c_out`.
  - The FSM moves to DONE.
- DONE: `done=1` for exactly one cycle; the next edge returns to IDLE unconditionally.
- `d` holds its value until the next accepted start completes. The result register shifts internally; `d` updates only at completion.
- `start` is ignored in RUN and DONE; there is no queuing. Changes on `a`/`b` after capture have no effect.
- Arithmetic is modulo 2^(WIDTH+1):
  - a = b gives `d = 0`.
  - a < b gives a negative result with `d[WIDTH] = 1`.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `d=0`, `ovf=0`, carry 0, counter 0.
- Reset is asynchronous. Assertion mid-RUN aborts immediately: no `done`, and `d` clears to 0.
- Latency: start accepted at edge E0; `busy` is high from after E0 through edge E_WIDTH.
- `d` becomes valid and `done=1` in the cycle after E_WIDTH, and `busy=0` in that same cycle.
- The earliest next start is accepted at edge E_WIDTH+2, because IDLE must be reached first. Throughput is one operation per WIDTH+2 cycles.
- `done` and `busy` are never high together.
- `start` held high continuously starts a new operation every WIDTH+2 cycles.

## Configuration
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - The `ovf` port exists.
  - `ovf = (a[W-1] ^ b[W-1]) & (a[W-1] ^ d[W-1])`, using the captured MSBs.
  - `ovf` is registered with `d` and held with it.
- Undefined: no `ovf` port and no MSB capture logic; all other behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - state enum (`SS_IDLE`, `SS_RUN`, `SS_DONE`), 2-bit encoding;
  - `ALU_DEFAULT_WIDTH = 8`;
  - the counter width is derived as `$clog2(WIDTH)`.
- One sub-module, `full_adder` (a, b, cin → s, cout), instantiated once for the serial slice. It is the same cell used by the ripple-carry adder.

## Test plan
- WIDTH=8, a=23, b=12, start pulse:
  - `busy` is high for 8 cycles, then a `done` pulse.
  - `d = 9'h00B` (11).
- a=3, b=8: `d = 9'h1FB` (−5), `d[8]=1`.
- a=8, b=8 and a=0, b=0: `d = 0` in both runs; `done` exactly one cycle each.
- a=71, b=35 started; `start` re-pulsed with a=1, b=1 during RUN:
  - the second request is ignored;
  - `d = 36` (9'h024), only one `done`.
- Reset mid-operation: a=200, b=100; `rst_n` pulled low 4 cycles after start.
  - `busy`, `done` and `d` go to 0 immediately.
  - A new start with a=200, b=100 yields `d = 100`.
- With SERIAL_SUB_OVF_EN:
  - a=8'h80, b=8'h01 → `ovf=1`, `d[7:0] = 8'h7F`.
  - a=5, b=3 → `ovf=0`.
